// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Arbiter states, default byte width, header byte helper.
package uart_pkg;

   localparam int DBIT_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD
   } arb_state_t;

   // Header byte = base OR source id (base keeps id bits clear).
   function automatic logic [31:0] hdr_byte(
      input logic [31:0] base,
      input logic [31:0] id
   );
      return base | id;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request above last_grant,
// wrapping. Ports: req, last_grant in; any_req, winner out.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic                    any_req,
   output logic [$clog2(NREQ)-1:0] winner
);

   localparam int GW = $clog2(NREQ);

   logic [NREQ-1:0] hi_mask;
   logic [NREQ-1:0] hi_req;

   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         hi_mask[i] = (i > int'(last_grant));
      end
   end

   assign hi_req  = req & hi_mask;
   assign any_req = |req;

   // Requests above the last grant win; otherwise wrap to the bottom.
   always_comb begin
      winner = '0;
      if (|hi_req) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) winner = GW'(i);
         end
      end else begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) winner = GW'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin share of one UART TX FIFO write port.
// Ports: req_* byte streams in, w_data/wr_uart/tx_full to uart, status.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int             NREQ     = 4,
   parameter int             DBIT     = DBIT_DEFAULT,
   parameter int             HDR_EN   = 1,
   parameter logic [DBIT-1:0] HDR_BASE = 8'hA0,
   parameter int             MAX_LEN  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ*DBIT-1:0]    req_data,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic [DBIT-1:0]         w_data,
   output logic                    wr_uart,
   input  logic                    tx_full,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    err_trunc
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_LEN + 1);

   arb_state_t    state;
   arb_state_t    state_n;
   logic [GW-1:0] last_grant;
   logic [CW-1:0] count;
   logic          any_req;
   logic [GW-1:0] winner;
   logic          xfer;
   logic          g_last;
   logic          hit_max;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .any_req    (any_req),
      .winner     (winner)
   );

   assign g_last  = req_last[grant_id];
   assign hit_max = (count + CW'(1)) == CW'(MAX_LEN);
   assign busy    = (state != IDLE);

   always_comb begin
      state_n   = state;
      req_ready = '0;
      wr_uart   = 1'b0;
      w_data    = '0;
      xfer      = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_n = (HDR_EN != 0) ? HEADER : PAYLOAD;
            end
         end
         HEADER: begin
            wr_uart = !tx_full;
            w_data  = DBIT'(hdr_byte(32'(HDR_BASE),
                                     32'(grant_id)));
            if (!tx_full) state_n = PAYLOAD;
         end
         PAYLOAD: begin
            xfer                = req_valid[grant_id] & !tx_full;
            wr_uart             = xfer;
            req_ready[grant_id] = xfer;
            w_data = req_data[int'(grant_id)*DBIT +: DBIT];
            // Last byte or length cap both release the grant.
            if (xfer && (g_last || hit_max)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NREQ - 1);
         count      <= '0;
         err_trunc  <= 1'b0;
      end else begin
         state     <= state_n;
         err_trunc <= xfer && !g_last && hit_max;
         if (state == IDLE && any_req) begin
            grant_id   <= winner;
            last_grant <= winner;
            count      <= '0;
         end else if (xfer) begin
            count <= count + CW'(1);
         end
      end
   end

endmodule
